// File: rtl/booth4_pp_streamer_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family.
//   BOOTH_GRP_W        : width of one Booth window {b[2i+1], b[2i], b[2i-1]}
//   DIG_*              : 3-bit signed codes for the Booth digits -2..+2
//   S_IDLE / S_EMIT    : state encodings of the partial-product streamer FSM
//   booth_sel_t        : one-hot-ish multiplicand select {neg, one, two}
package booth4_pp_streamer_pkg;

  localparam int BOOTH_GRP_W = 3;

  localparam logic signed [2:0] DIG_ZERO = 3'sb000;
  localparam logic signed [2:0] DIG_P1   = 3'sb001;
  localparam logic signed [2:0] DIG_P2   = 3'sb010;
  localparam logic signed [2:0] DIG_M1   = 3'sb111;
  localparam logic signed [2:0] DIG_M2   = 3'sb110;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // neg : negate the selected multiple
  // one : select 1*a
  // two : select 2*a
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

endpackage

// File: rtl/booth4_digit_enc.sv
// Radix-4 Booth digit encoder (purely combinational).
// Ports:
//   win   in  3  Booth window {b[2i+1], b[2i], b[2i-1]}
//   sel   out    multiplicand select {neg, one, two}
//   digit out 3  signed Booth digit in {-2,-1,0,+1,+2}
module booth4_digit_enc
  import booth4_pp_streamer_pkg::*;
(
  input  logic [BOOTH_GRP_W-1:0] win,
  output booth_sel_t             sel,
  output logic signed [2:0]      digit
);

  always_comb begin
    sel   = '0;
    digit = DIG_ZERO;
    case (win)
      3'b001, 3'b010: begin
        sel.one = 1'b1;
        digit   = DIG_P1;
      end
      3'b011: begin
        sel.two = 1'b1;
        digit   = DIG_P2;
      end
      3'b100: begin
        sel.neg = 1'b1;
        sel.two = 1'b1;
        digit   = DIG_M2;
      end
      3'b101, 3'b110: begin
        sel.neg = 1'b1;
        sel.one = 1'b1;
        digit   = DIG_M1;
      end
      default: begin
        sel   = '0;
        digit = DIG_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/booth4_pp_streamer.sv
// Radix-4 Booth partial-product streamer.
// Accepts one signed WIDTH x WIDTH operand pair over valid/ready and emits
// its Booth partial products one per beat, each already shifted by 4^idx
// and sign-extended to 2*WIDTH bits. The beats of one operation sum,
// modulo 2^(2*WIDTH), to signed(a)*signed(b).
//
// Optional feature macro: SKIP_ZERO_PP_EN
//   undefined : every group is emitted, idx 0..NPP-1, last at idx NPP-1.
//   defined   : zero-digit groups take no beat; last on the highest nonzero
//               group; an all-zero multiplier emits a single zero beat at
//               idx NPP-1.
//
// Ports:
//   sys_clk    in            clock, rising edge
//   sys_rst_n  in            asynchronous active-low reset
//   in_valid   in            operand pair valid
//   in_ready   out           ready for an operand pair (state IDLE)
//   a_in       in  WIDTH     multiplicand, signed
//   b_in       in  WIDTH     multiplier, signed (Booth recoded)
//   pp_valid   out           beat valid
//   pp_ready   in            downstream accepts beat
//   pp_data    out 2*WIDTH   digit * a * 4^idx, mod 2^(2*WIDTH)
//   pp_digit   out 3         Booth digit, signed
//   pp_idx     out IDX_W     group index
//   pp_last    out           final beat of the operation
//   busy       out           operation in progress (state EMIT)
module booth4_pp_streamer
  import booth4_pp_streamer_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NPP   = WIDTH / 2,
  localparam int IDX_W = $clog2(NPP)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   a_in,
  input  logic        [WIDTH-1:0]   b_in,
  output logic                      pp_valid,
  input  logic                      pp_ready,
  output logic signed [2*WIDTH-1:0] pp_data,
  output logic signed [2:0]         pp_digit,
  output logic        [IDX_W-1:0]   pp_idx,
  output logic                      pp_last,
  output logic                      busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPP - 1);

  logic [0:0]                state;
  logic signed [WIDTH-1:0]   a_reg;
  logic        [WIDTH-1:0]   b_reg;
  logic        [IDX_W-1:0]   idx;

  logic        [IDX_W-1:0]   first_idx;
  logic        [IDX_W-1:0]   next_idx;
  logic                      last_grp;

  logic        [WIDTH:0]     b_ext;
  logic [BOOTH_GRP_W-1:0]    win;
  booth_sel_t                sel;
  logic signed [2:0]         digit;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] term;
  logic signed [2*WIDTH-1:0] shifted;

  // Select 0/a/2a, then take the true two's complement for negative digits.
  // In 2*WIDTH bits even -2 * -2^(WIDTH-1) = 2^WIDTH is exact.
  function automatic logic signed [2*WIDTH-1:0] booth_term(
    input logic signed [2*WIDTH-1:0] x,
    input booth_sel_t                s
  );
    logic signed [2*WIDTH-1:0] mag;
    mag = s.two ? (x <<< 1) : (s.one ? x : '0);
    return s.neg ? -mag : mag;
  endfunction

  // ---------------------------------------------------------------------
  // Group sequencing
  // ---------------------------------------------------------------------
`ifdef SKIP_ZERO_PP_EN
  logic [WIDTH:0]   b_in_ext;
  logic [NPP-1:0]   in_mask;
  logic [NPP-1:0]   nz_mask;

  assign b_in_ext = {b_in, 1'b0};

  // Nonzero-digit mask of the incoming multiplier, captured at acceptance.
  for (genvar g = 0; g < NPP; g++) begin : g_grp
    booth_sel_t        grp_sel;
    logic signed [2:0] grp_digit;

    booth4_digit_enc u_grp_enc (
      .win   (b_in_ext[2*g +: BOOTH_GRP_W]),
      .sel   (grp_sel),
      .digit (grp_digit)
    );

    assign in_mask[g] = (grp_digit != DIG_ZERO);
  end

  // Lowest nonzero group; an all-zero mask falls back to the top group so
  // that exactly one (zero) beat carries pp_last.
  function automatic logic [IDX_W-1:0] first_nz(input logic [NPP-1:0] m);
    logic [IDX_W-1:0] r;
    r = LAST_IDX;
    for (int g = NPP - 1; g >= 0; g--) begin
      if (m[g]) r = IDX_W'(g);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_nz(
    input logic [NPP-1:0]   m,
    input logic [IDX_W-1:0] cur
  );
    logic [IDX_W-1:0] r;
    r = cur;
    for (int g = NPP - 1; g >= 0; g--) begin
      if (m[g] && (g > int'(cur))) r = IDX_W'(g);
    end
    return r;
  endfunction

  assign first_idx = first_nz(in_mask);
  assign next_idx  = next_nz(nz_mask, idx);
  assign last_grp  = (((nz_mask >> idx) >> 1) == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      nz_mask <= '0;
    end else if (state == S_IDLE && in_valid) begin
      nz_mask <= in_mask;
    end
  end
`else
  assign first_idx = '0;
  assign next_idx  = idx + 1'b1;
  assign last_grp  = (idx == LAST_IDX);
`endif

  // ---------------------------------------------------------------------
  // FSM and operand / index registers
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            idx   <= first_idx;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pp_ready) begin
            if (last_grp) state <= S_IDLE;
            else          idx   <= next_idx;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Beat datapath: window select, Booth encode, select/negate, shift
  // ---------------------------------------------------------------------
  // b[-1] is the implicit zero below the LSB.
  assign b_ext = {b_reg, 1'b0};

  always_comb begin
    win = '0;
    for (int g = 0; g < NPP; g++) begin
      if (idx == IDX_W'(g)) win = b_ext[2*g +: BOOTH_GRP_W];
    end
  end

  booth4_digit_enc u_cur_enc (
    .win   (win),
    .sel   (sel),
    .digit (digit)
  );

  assign a_ext   = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
  assign term    = booth_term(a_ext, sel);
  assign shifted = term << {idx, 1'b0};

  // Outputs depend only on registered state; they are forced to their
  // reset values outside EMIT so an idle block presents a clean bus.
  assign busy     = (state == S_EMIT);
  assign in_ready = (state == S_IDLE);
  assign pp_valid = busy;
  assign pp_data  = busy ? shifted : '0;
  assign pp_digit = busy ? digit : DIG_ZERO;
  assign pp_idx   = busy ? idx : '0;
  assign pp_last  = busy && last_grp;

endmodule

// File: tb/tb_booth4_pp_streamer.sv
// Self-checking bench for booth4_pp_streamer (WIDTH=16). Build with
// SKIP_ZERO_PP_EN defined to exercise the zero-skipping variant.
module tb_booth4_pp_streamer;

  localparam int W   = 16;
  localparam int NPP = W / 2;
`ifdef SKIP_ZERO_PP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic        pp_ready  = 1'b0;
  logic [15:0] a_in      = '0;
  logic [15:0] b_in      = '0;
  logic        in_ready;
  logic        pp_valid;
  logic        pp_last;
  logic        busy;
  logic [31:0] pp_data;
  logic [2:0]  pp_digit;
  logic [2:0]  pp_idx;

  booth4_pp_streamer #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_data   (pp_data),
    .pp_digit  (pp_digit),
    .pp_idx    (pp_idx),
    .pp_last   (pp_last),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          idx;
    int          digit;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    first_lat;

  // Reference: digit_i = -2*b[2i+1] + b[2i] + b[2i-1]; beat = digit*a*4^i.
  task automatic build_expected(input logic [15:0] a, input logic [15:0] b);
    beat_t e;
    exp_q.delete();
    for (int i = 0; i < NPP; i++) begin
      int     hi, mid, lo, d;
      longint p;
      hi  = int'(b[2*i+1]);
      mid = int'(b[2*i]);
      lo  = (i == 0) ? 0 : int'(b[2*i-1]);
      d   = -2 * hi + mid + lo;
      if (SKIP && d == 0) continue;
      p = longint'(d) * longint'($signed(a)) * (longint'(1) << (2 * i));
      e.idx = i; e.digit = d; e.data = p[31:0]; e.last = 1'b0;
      exp_q.push_back(e);
    end
    if (exp_q.size() == 0) begin
      e.idx = NPP - 1; e.digit = 0; e.data = '0; e.last = 1'b0;
      exp_q.push_back(e);
    end
    exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  // Index of the first beat differing from the model, -1 if identical.
  function automatic int first_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got[i].idx != exp_q[i].idx || got[i].digit != exp_q[i].digit ||
          got[i].data !== exp_q[i].data || got[i].last != exp_q[i].last)
        return i;
    end
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [31:0] got_sum();
    logic [31:0] s;
    s = '0;
    foreach (got[i]) s = s + got[i].data;
    return s;
  endfunction

  function automatic int got_lasts();
    int c;
    c = 0;
    foreach (got[i]) if (got[i].last) c++;
    return c;
  endfunction

  // Drives one operation and records every accepted beat into got[].
  // Entered and left on a falling edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int stall_pct, output bit to);
    int guard;
    bit done;
    beat_t bt;
    got.delete();
    to = 1'b0;
    first_lat = -1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    if (!in_ready) to = 1'b1;
    a_in = a; b_in = b; in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom);
    guard = 0;
    done = 1'b0;
    while (!done && guard < 400) begin
      pp_ready = ($urandom_range(0, 99) >= stall_pct);
      if (pp_valid && first_lat < 0) first_lat = guard;
      if (pp_valid && pp_ready) begin
        bt.idx = int'(pp_idx); bt.digit = int'($signed(pp_digit));
        bt.data = pp_data; bt.last = pp_last;
        got.push_back(bt);
        if (pp_last) done = 1'b1;
      end
      @(negedge sys_clk);
      guard++;
    end
    pp_ready = 1'b0;
    if (!done) to = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    n_cmp++;
    if (pp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pp_valid: got %b need 0", pp_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_cmp++;
    if (pp_last !== 1'b0) begin n_fail++; $display("FAIL reset_pp_last: got %b need 0", pp_last); end
    n_cmp++;
    if ({pp_data, pp_digit, pp_idx} !== 38'd0)
      begin n_fail++; $display("FAIL reset_pp_bus: got data %h digit %0d idx %0d need zeros", pp_data, pp_digit, pp_idx); end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_basic();
    bit to;
    int d;
    build_expected(16'd3, 16'd5);
    run_op(16'd3, 16'd5, 0, to);
    d = first_diff();
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: op did not complete"); end
    n_cmp++;
    if (first_lat != 0) begin n_fail++; $display("FAIL basic_latency: got %0d extra cycles need 0", first_lat); end
    n_cmp++;
    if (got.size() != (SKIP ? 2 : 8)) begin n_fail++; $display("FAIL basic_count: got %0d beats need %0d", got.size(), SKIP ? 2 : 8); end
    n_cmp++;
    if (d != -1) begin n_fail++; $display("FAIL basic_beats: first difference at beat %0d", d); end
    n_cmp++;
    if (got.size() >= 2 && (got[0].data !== 32'd3 || got[1].data !== 32'd12 || got[1].idx != 1))
      begin n_fail++; $display("FAIL basic_data: got %h/%h idx1=%0d need 3/c idx1=1", got[0].data, got[1].data, got[1].idx); end
    n_cmp++;
    if (got_sum() !== 32'd15) begin n_fail++; $display("FAIL basic_sum: got %h need f", got_sum()); end
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: busy %b in_ready %b need 0/1", busy, in_ready); end
  endtask

  task automatic test_boundary();
    logic [15:0] av[6] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h1234, 16'h7FFF};
    logic [15:0] bv[6] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF};
    logic [31:0] sv[6] = '{32'h0000_8000, 32'h4000_0000, 32'h0000_8000, 32'hC000_8000, 32'h0, 32'hFFFF_8001};
    int cnt0[2] = '{8, 1};
    bit to;
    int d;
    for (int k = 0; k < 6; k++) begin
      build_expected(av[k], bv[k]);
      run_op(av[k], bv[k], 30, to);
      d = first_diff();
      n_cmp++;
      if (to || d != -1)
        begin n_fail++; $display("FAIL bound_beats[%0d]: timeout %b first diff %0d", k, to, d); end
      n_cmp++;
      if (got_sum() !== sv[k])
        begin n_fail++; $display("FAIL bound_sum[%0d]: got %h need %h", k, got_sum(), sv[k]); end
      if (bv[k] == 16'h0000 || bv[k] == 16'hFFFF) begin
        n_cmp++;
        if (got.size() != cnt0[int'(SKIP)] || (got.size() > 0 && got[got.size()-1].idx != (bv[k] == 16'h0 || !SKIP ? 7 : 0)))
          begin n_fail++; $display("FAIL bound_count[%0d]: got %0d beats need %0d", k, got.size(), cnt0[int'(SKIP)]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h_data;
    logic [2:0]  h_digit, h_idx;
    logic        h_last;
    bit          stalled, done;
    int          guard, d;
    beat_t       bt;
    build_expected(16'h1234, 16'h5555);
    got.delete();
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge sys_clk); guard++; end
    a_in = 16'h1234; b_in = 16'h5555; in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
    pp_ready = 1'b1;
    stalled = 1'b0; done = 1'b0; guard = 0;
    while (!done && guard < 200) begin
      if (pp_valid && pp_idx == 3'd2 && !stalled) begin
        stalled = 1'b1;
        pp_ready = 1'b0;
        h_data = pp_data; h_digit = pp_digit; h_idx = pp_idx; h_last = pp_last;
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
          @(negedge sys_clk);
          n_cmp++;
          if (pp_valid !== 1'b1 || in_ready !== 1'b0 || pp_data !== h_data ||
              pp_digit !== h_digit || pp_idx !== h_idx || pp_last !== h_last)
            begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b ready %b data %h idx %0d need 1/0 %h %0d", k, pp_valid, in_ready, pp_data, pp_idx, h_data, h_idx); end
        end
        in_valid = 1'b0;
        pp_ready = 1'b1;
      end
      if (pp_valid && pp_ready) begin
        bt.idx = int'(pp_idx); bt.digit = int'($signed(pp_digit));
        bt.data = pp_data; bt.last = pp_last;
        got.push_back(bt);
        if (pp_last) begin
          done = 1'b1;
          n_cmp++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_last_ready: got %b need 0", in_ready); end
        end
      end
      @(negedge sys_clk);
      guard++;
    end
    pp_ready = 1'b0;
    d = first_diff();
    n_cmp++;
    if (!done || !stalled || d != -1)
      begin n_fail++; $display("FAIL bp_beats: done %b stalled %b first diff %0d", done, stalled, d); end
    n_cmp++;
    if (got_sum() !== ref_product(16'h1234, 16'h5555))
      begin n_fail++; $display("FAIL bp_sum: got %h need %h", got_sum(), ref_product(16'h1234, 16'h5555)); end
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || pp_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_after: busy %b in_ready %b pp_valid %b need 0/1/0", busy, in_ready, pp_valid); end
  endtask

  task automatic test_reset_mid();
    int guard, d;
    bit to;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge sys_clk); guard++; end
    a_in = 16'h0F0F; b_in = 16'h5555; in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
    pp_ready = 1'b1;
    guard = 0;
    while (!(pp_valid && pp_idx == 3'd4) && guard < 50) begin @(negedge sys_clk); guard++; end
    n_cmp++;
    if (!(pp_valid && pp_idx == 3'd4)) begin n_fail++; $display("FAIL rstmid_reach: idx4 not reached, idx %0d", pp_idx); end
    #1 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pp_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_async: pp_valid %b in_ready %b busy %b need 0/1/0", pp_valid, in_ready, busy); end
    n_cmp++;
    if ({pp_data, pp_digit, pp_idx, pp_last} !== 39'd0)
      begin n_fail++; $display("FAIL rstmid_bus: data %h digit %0d idx %0d last %b need zeros", pp_data, pp_digit, pp_idx, pp_last); end
    pp_ready = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_cmp++;
    if (pp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_reissue: pp_valid %b need 0", pp_valid); end
    build_expected(16'hBEEF, 16'h1357);
    run_op(16'hBEEF, 16'h1357, 20, to);
    d = first_diff();
    n_cmp++;
    if (to || d != -1 || got.size() == 0 || got[0].idx != 0)
      begin n_fail++; $display("FAIL rstmid_restart: timeout %b first diff %0d beats %0d", to, d, got.size()); end
  endtask

  task automatic test_random();
    logic [15:0] sp[4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [15:0] a, b;
    bit to;
    int d;
    for (int n = 0; n < 2000; n++) begin
      a = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : 16'($urandom);
      build_expected(a, b);
      run_op(a, b, $urandom_range(0, 50), to);
      d = first_diff();
      n_cmp++;
      if (to || d != -1)
        begin n_fail++; $display("FAIL rand_beats[%0d]: a %h b %h timeout %b first diff %0d", n, a, b, to, d); end
      n_cmp++;
      if (got_sum() !== ref_product(a, b))
        begin n_fail++; $display("FAIL rand_sum[%0d]: a %h b %h got %h need %h", n, a, b, got_sum(), ref_product(a, b)); end
      n_cmp++;
      if (got_lasts() != 1)
        begin n_fail++; $display("FAIL rand_last[%0d]: got %0d last beats need 1", n, got_lasts()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
